alu_wb_stage: RTL and testbench
===============================

Name: alu_wb_stage

Overview:
- Execute-to-writeback stage directly downstream of alu_32.
- Captures each ALU result together with its destination register tag into a small in-order buffer, and drains it to the register-file write port over a valid/ready handshake.
- Maintains the architectural NZCV flag register, updated from the ALU flag outputs.
- Provides combinational condition-code evaluation against the committed flags for branch logic.

Parameters:
- DATA_W, 32, result width; matches the alu_32 result width.
- TAG_W, 5, destination register index width.
- DEPTH, 2, buffer entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  synchronous discard of all buffered entries.
- in_valid  in  1  ALU beat present.
- in_ready  out  1  stage can accept a beat.
- in_result  in  DATA_W  ALU result.
- in_overflow  in  1  ALU overflow (V).
- in_c_out  in  1  ALU carry/borrow (C).
- in_negative  in  1  ALU negative (N); not used, see Behaviour.
- in_set_flags  in  1  beat updates NZCV.
- in_wr_en  in  1  beat writes the register file.
- in_rd  in  TAG_W  destination register.
- out_valid  out  1  head entry valid.
- out_ready  in  1  register file accepts the head entry.
- out_data  out  DATA_W  head result.
- out_rd  out  TAG_W  head destination.
- out_wr_en  out  1  head write enable.
- flags  out  4  committed {N,Z,C,V}.
- cond_sel  in  3  condition select, encoded as cond_e.
- cond_true  out  1  cond_sel evaluated against flags.
- beat_count  out  32  count of accepted beats.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Buffer count and pointers go to 0; flags go to 4'b0000; beat_count goes to 0; out_valid goes to 0.
  - in_ready is forced to 0 while rst_n=0.
- Accept occurs when in_valid & in_ready.
  - in_ready = rst_n & (count < DEPTH). It has no dependence on out_ready, so a full buffer with a simultaneous pop still refuses the incoming beat.
- Latency: an accepted beat appears at out_* on the next cycle when the buffer was empty. There is no combinational in-to-out bypass.
- Drain occurs when out_valid & out_ready.
  - out_* come from the head entry.
  - out_valid = (count != 0).
  - out_* hold stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Flag update:
  - On accept with in_set_flags=1, flags take {N,Z,C,V} on the next edge:
    - N = in_result[DATA_W-1]
    - Z = (in_result == 0), recomputed locally; alu_32 provides no zero input to this stage.
    - C = in_c_out
    - V = in_overflow
  - Flags update at accept time in program order, independent of drain.
  - With in_set_flags=0, or with no accept, flags hold.
- C semantics: C holds the raw alu_32 carry. After ADD it is the carry-out. After SUB it is the borrow, so C=1 means A < B unsigned.
- cond_true is combinational from the registered flags, so it reflects the flags from the previous edge. cond_e encodings:
  - 0 AL = 1
  - 1 EQ = Z
  - 2 NE = !Z
  - 3 LT = N^V
  - 4 GE = !(N^V)
  - 5 LTU = C
  - 6 GEU = !C
  - 7 MI = N
- flush:
  - Next edge: count and pointers go to 0, and out_valid drops.
  - A beat presented in the same cycle as flush is dropped. It causes no buffer write, no flag update and no beat_count increment.
  - Flags from earlier accepts are retained.
  - flush has priority over a simultaneous pop.
- beat_count increments on each non-flushed accept and wraps from 2^32-1 to 0.
- Reset mid-operation: buffered entries are lost and flags are cleared. Upstream re-presents any beat that was not accepted.

Decomposition:
- alu_pkg holds:
  - flags_t, a packed struct {n,z,c,v};
  - cond_e, a 3-bit enum with the encodings above;
  - wb_entry_t, a packed struct {data, rd, wr_en};
  - ALU opcode constants ADD=2'b00, SUB=2'b01, AND=2'b10, OR=2'b11.
- Sub-module wb_fifo is a parameterised sync FIFO of wb_entry_t with count output and flush. alu_wb_stage adds the flag register, condition logic and counter around it.

Test Plan:
- Reset, then push in_result=32'h0000_0005, rd=3, wr_en=1, set_flags=1, C=0, V=0 with out_ready=1:
  - out_valid=1 the next cycle with out_data=5 and out_rd=3;
  - flags=4'b0000;
  - cond_sel=GE gives 1.
- Push in_result=0 with set_flags=1, then in_result=32'h8000_0000 with set_flags=0:
  - flags=Z (4'b0100) after the first beat, and still 4'b0100 after the second;
  - cond_sel EQ=1, NE=0.
- Hold out_ready=0 and push 3 beats (A, B, C):
  - in_ready=0 after 2 accepts, so C is held upstream;
  - raise out_ready: A and B drain in order, then C is accepted; beat_count=3.
- At full, assert in_valid and out_ready together:
  - the push is refused and the pop occurs;
  - count goes 2 then 1, and in_ready=1 the next cycle.
- Push SUB-style beat with C=1, N=1, V=0 and set_flags=1, then assert flush with a new beat on in_* in the same cycle:
  - out_valid=0 the next cycle and the flushed beat never appears;
  - flags stay N,C (4'b1010);
  - LTU=1, LT=1.
- Deassert rst_n for one edge while 2 entries are buffered:
  - out_valid=0, flags=0 and beat_count=0;
  - in_ready=0 during reset and 1 after.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU writeback slice: flag register layout, condition
// codes, writeback buffer entry and ALU opcode constants.
package alu_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_TAG_W  = 5;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    typedef enum logic [2:0] {
        AL  = 3'd0,
        EQ  = 3'd1,
        NE  = 3'd2,
        LT  = 3'd3,
        GE  = 3'd4,
        LTU = 3'd5,
        GEU = 3'd6,
        MI  = 3'd7
    } cond_e;

    typedef struct packed {
        logic [WB_DATA_W-1:0] data;
        logic [WB_TAG_W-1:0]  rd;
        logic                 wr_en;
    } wb_entry_t;

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] AND = 2'b10;
    localparam logic [1:0] OR  = 2'b11;

    // C is the raw alu_32 carry, so after SUB it is a borrow: LTU tests C=1.
    function automatic logic cond_eval(input flags_t f, input cond_e sel);
        logic r;
        r = 1'b1;
        case (sel)
            AL:      r = 1'b1;
            EQ:      r = f.z;
            NE:      r = ~f.z;
            LT:      r = f.n ^ f.v;
            GE:      r = ~(f.n ^ f.v);
            LTU:     r = f.c;
            GEU:     r = ~f.c;
            MI:      r = f.n;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order sync FIFO of writeback entries with occupancy count and flush.
module wb_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  wb_entry_t                wr_entry,
    input  logic                     pop,
    output wb_entry_t                rd_entry,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    wb_entry_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_entry;
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_entry = mem[rd_ptr];
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);

endmodule

// File: rtl/alu_wb_stage.sv
// Execute-to-writeback stage: buffers ALU results for the register file,
// owns the committed NZCV flags and evaluates branch conditions against them.
module alu_wb_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int TAG_W  = WB_TAG_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_overflow,
    input  logic              in_c_out,
    input  logic              in_negative,
    input  logic              in_set_flags,
    input  logic              in_wr_en,
    input  logic [TAG_W-1:0]  in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_rd,
    output logic              out_wr_en,
    output logic [3:0]        flags,
    input  logic [2:0]        cond_sel,
    output logic              cond_true,
    output logic [31:0]       beat_count
);

    logic [$clog2(DEPTH):0] fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   accept;
    logic                   drain;
    wb_entry_t              push_entry;
    wb_entry_t              head;
    flags_t                 flags_q;
    logic                   unused_sigs;

    // Ready ignores out_ready: a full buffer refuses even when popping.
    assign in_ready = rst_n & ~fifo_full;
    assign accept   = in_valid & in_ready & ~flush;
    assign drain    = out_valid & out_ready & ~flush;

    assign push_entry = '{data: in_result, rd: in_rd, wr_en: in_wr_en};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .push     (accept),
        .wr_entry (push_entry),
        .pop      (drain),
        .rd_entry (head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign out_valid = ~fifo_empty;
    assign out_data  = head.data;
    assign out_rd    = head.rd;
    assign out_wr_en = head.wr_en;

    // N comes from the result MSB and Z is recomputed here; in_negative is redundant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q    <= '0;
            beat_count <= '0;
        end else if (accept) begin
            beat_count <= beat_count + 32'd1;
            if (in_set_flags) begin
                flags_q <= '{n: in_result[DATA_W-1],
                             z: (in_result == '0),
                             c: in_c_out,
                             v: in_overflow};
            end
        end
    end

    assign flags       = flags_q;
    assign cond_true   = cond_eval(flags_q, cond_e'(cond_sel));
    assign unused_sigs = ^{in_negative, fifo_count};

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed bench for alu_wb_stage; a negedge monitor drains a scoreboard queue.
module tb_alu_wb_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready;
    logic [31:0] in_result;
    logic        in_overflow, in_c_out, in_negative, in_set_flags, in_wr_en;
    logic [4:0]  in_rd;
    logic        out_valid, out_ready, out_wr_en;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic [3:0]  flags;
    logic [2:0]  cond_sel;
    logic        cond_true;
    logic [31:0] beat_count;

    int        n_vec = 0;
    int        n_err = 0;
    wb_entry_t exp_q[$];
    wb_entry_t mon_e;

    always #5 clk = ~clk;

    alu_wb_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_overflow(in_overflow), .in_c_out(in_c_out), .in_negative(in_negative),
        .in_set_flags(in_set_flags), .in_wr_en(in_wr_en), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .out_wr_en(out_wr_en), .flags(flags),
        .cond_sel(cond_sel), .cond_true(cond_true), .beat_count(beat_count)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] r, input logic [4:0] rd, input logic we,
                         input logic sf, input logic c, input logic v);
        in_valid     = 1'b1;
        in_result    = r;
        in_rd        = rd;
        in_wr_en     = we;
        in_set_flags = sf;
        in_c_out     = c;
        in_overflow  = v;
        in_negative  = r[31];
    endtask

    task automatic expect_beat(input logic [31:0] r, input logic [4:0] rd, input logic we);
        wb_entry_t e;
        e.data  = r;
        e.rd    = rd;
        e.wr_en = we;
        exp_q.push_back(e);
    endtask

    // mask bit i is the expected cond_true for cond_sel == i
    task automatic chk_conds(input logic [7:0] mask, input string tag);
        for (int i = 0; i < 8; i++) begin
            cond_sel = 3'(i);
            #1;
            chk($sformatf("%s cond%0d", tag, i), {31'b0, cond_true}, {31'b0, mask[i]});
        end
    endtask

    // Scoreboard: compare the head on every cycle that drains.
    always @(negedge clk) begin
        if (rst_n && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL drain_unexpected: got data %h rd %0d expected no entry", out_data, out_rd);
            end else begin
                mon_e = exp_q.pop_front();
                chk("drain data", out_data, mon_e.data);
                chk("drain rd", {27'b0, out_rd}, {27'b0, mon_e.rd});
                chk("drain wr_en", {31'b0, out_wr_en}, {31'b0, mon_e.wr_en});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_result = '0; in_overflow = 1'b0;
        in_c_out = 1'b0; in_negative = 1'b0; in_set_flags = 1'b0; in_wr_en = 1'b0;
        in_rd = '0; out_ready = 1'b0; cond_sel = 3'd0;

        // reset state
        repeat (2) step();
        chk("rst in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst flags", {28'b0, flags}, 32'd0);
        chk("rst beat_count", beat_count, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post-rst in_ready", {31'b0, in_ready}, 32'd1);

        // single beat, one-cycle latency
        out_ready = 1'b1;
        drive(32'h0000_0005, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_beat(32'h0000_0005, 5'd3, 1'b1);
        step();
        in_valid = 1'b0;
        chk("t1 out_valid", {31'b0, out_valid}, 32'd1);
        chk("t1 out_data", out_data, 32'd5);
        chk("t1 out_rd", {27'b0, out_rd}, 32'd3);
        chk("t1 flags", {28'b0, flags}, 32'd0);
        cond_sel = GE;
        #1;
        chk("t1 GE", {31'b0, cond_true}, 32'd1);
        step();

        // zero result sets Z; set_flags=0 beat leaves flags alone
        drive(32'h0000_0000, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_beat(32'h0000_0000, 5'd4, 1'b1);
        step();
        chk("t2 flags Z", {28'b0, flags}, 32'h4);
        drive(32'h8000_0000, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_beat(32'h8000_0000, 5'd5, 1'b0);
        step();
        in_valid = 1'b0;
        chk("t2 flags hold", {28'b0, flags}, 32'h4);
        chk_conds(8'b0101_0011, "Z");
        step();
        step();
        chk("t2 drained", {31'b0, out_valid}, 32'd0);
        chk("t2 beat_count", beat_count, 32'd3);

        // backpressure: third beat held upstream until a slot frees
        out_ready = 1'b0;
        drive(32'h0000_00A0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_beat(32'h0000_00A0, 5'd6, 1'b1);
        step();
        drive(32'h0000_00B0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_beat(32'h0000_00B0, 5'd7, 1'b1);
        step();
        drive(32'h0000_00C0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t3 full in_ready", {31'b0, in_ready}, 32'd0);
        step();
        step();
        chk("t3 held in_ready", {31'b0, in_ready}, 32'd0);
        chk("t3 held out_data", out_data, 32'h0000_00A0);
        expect_beat(32'h0000_00C0, 5'd8, 1'b1);
        out_ready = 1'b1;
        step();
        chk("t3 slot free", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        step();
        chk("t3 beat_count", beat_count, 32'd6);

        // full with simultaneous pop: push refused, pop happens
        out_ready = 1'b0;
        drive(32'h0000_1111, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_beat(32'h0000_1111, 5'd10, 1'b1);
        step();
        drive(32'h0000_2222, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_beat(32'h0000_2222, 5'd11, 1'b1);
        step();
        drive(32'h0000_3333, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        chk("t4 full refuse", {31'b0, in_ready}, 32'd0);
        step();
        chk("t4 after pop in_ready", {31'b0, in_ready}, 32'd1);
        chk("t4 head is second", out_data, 32'h0000_2222);
        in_valid = 1'b0;
        step();
        step();
        chk("t4 empty", {31'b0, out_valid}, 32'd0);
        chk("t4 beat_count", beat_count, 32'd8);

        // flush drops buffer and same-cycle beat, keeps earlier flags
        out_ready = 1'b0;
        drive(32'hFFFF_FFFE, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
        expect_beat(32'hFFFF_FFFE, 5'd7, 1'b1);
        step();
        chk("t5 flags NC", {28'b0, flags}, 32'hA);
        out_ready = 1'b1;
        flush = 1'b1;
        drive(32'h0000_0000, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        chk("t5 flush out_valid", {31'b0, out_valid}, 32'd0);
        chk("t5 flush flags", {28'b0, flags}, 32'hA);
        chk("t5 flush beat_count", beat_count, 32'd9);
        chk_conds(8'b1010_1101, "NC");
        step();
        chk("t5 stays empty", {31'b0, out_valid}, 32'd0);

        // reset with two buffered entries
        out_ready = 1'b0;
        drive(32'h0000_AAAA, 5'd13, 1'b1, 1'b1, 1'b1, 1'b1);
        expect_beat(32'h0000_AAAA, 5'd13, 1'b1);
        step();
        drive(32'h0000_BBBB, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_beat(32'h0000_BBBB, 5'd14, 1'b1);
        step();
        in_valid = 1'b0;
        chk("t6 buffered", {31'b0, out_valid}, 32'd1);
        chk("t6 flags CV", {28'b0, flags}, 32'h3);
        rst_n = 1'b0;
        #1;
        chk("t6 in_ready in reset", {31'b0, in_ready}, 32'd0);
        step();
        exp_q.delete();
        chk("t6 rst out_valid", {31'b0, out_valid}, 32'd0);
        chk("t6 rst flags", {28'b0, flags}, 32'd0);
        chk("t6 rst beat_count", beat_count, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("t6 in_ready after", {31'b0, in_ready}, 32'd1);

        // post-reset beat still flows
        out_ready = 1'b1;
        drive(32'h1234_5678, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_beat(32'h1234_5678, 5'd1, 1'b1);
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("t7 beat_count", beat_count, 32'd1);
        chk("scoreboard empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
